// File: rtl/timer_array_if.sv
// ----------------------------------------------------------------------------
// timer_array_if
// Register-bus bundle between the bridge (master) and a timer_array (slave).
//   addr   word address; block = addr[ADDR_W-1:2], word = addr[1:0]
//   we     single-cycle write strobe, sampled on the rising clock edge
//   wdata  write data
//   rdata  combinational read data for the current addr
// ----------------------------------------------------------------------------
interface timer_array_if #(
    parameter int ADDR_W = 6
) ();
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_array.sv
// ----------------------------------------------------------------------------
// timer_array
// N_CH independent down-counting timers behind one register window, sharing
// a single prescaler. Each channel has its own CTRL/PRESET/COUNT registers,
// a small mode FSM and a maskable write-1-to-clear pending bit.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   reset    asynchronous active-low reset
//   bus      register bus (slave side): addr, we, wdata in; rdata out
//   irq      per-channel interrupt = pending & CTRL.IM
//   irq_any  OR of irq
//
// Register map (word addresses)
//   block b < N_CH : w0 CTRL {PS,IM,MODE[1:0],EN}, w1 PRESET, w2 COUNT (RO)
//   block b = N_CH : w0 STATUS (pending, W1C), w1 PSC
//   everything else reads 0, writes ignored
// ----------------------------------------------------------------------------
module timer_array #(
    parameter int N_CH   = 2,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    timer_array_if.slave    bus,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);

    localparam int         BLK_W     = ADDR_W - 2;
    localparam logic [1:0] MODE_AUTO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blk;
    logic [1:0]       word;
    logic [N_CH-1:0]  ch_sel;
    logic             glb_sel;

    assign blk     = bus.addr[ADDR_W-1:2];
    assign word    = bus.addr[1:0];
    assign glb_sel = (blk == BLK_W'(N_CH));

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_sel[i] = (blk == BLK_W'(i));
        end
    end

    logic [N_CH-1:0] wr_ctrl;
    logic [N_CH-1:0] wr_preset;
    logic            wr_status;
    logic            wr_psc;
    logic [N_CH-1:0] status_clr;

    assign wr_ctrl    = {N_CH{bus.we && (word == 2'd0)}} & ch_sel;
    assign wr_preset  = {N_CH{bus.we && (word == 2'd1)}} & ch_sel;
    assign wr_status  = bus.we && glb_sel && (word == 2'd0);
    assign wr_psc     = bus.we && glb_sel && (word == 2'd1);
    assign status_clr = wr_status ? bus.wdata[N_CH-1:0] : '0;

    // ------------------------------------------------------------------
    // Shared prescaler: counts 0..PSC, tick while the counter equals PSC.
    // A PSC write restarts the count so the new period starts cleanly.
    // ------------------------------------------------------------------
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_cnt_q;
    logic             psc_tick;

    assign psc_tick = (psc_cnt_q == psc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q     <= '0;
            psc_cnt_q <= '0;
        end else if (wr_psc) begin
            // NOTE: non-blocking assignments in every clocked block, so all
            // registers update from the same pre-edge values.
            psc_q     <= bus.wdata[PSC_W-1:0];
            psc_cnt_q <= '0;
        end else if (psc_tick) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_q + PSC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel registers
    // ------------------------------------------------------------------
    state_t                      state_q [N_CH];
    state_t                      state_d [N_CH];
    logic [N_CH-1:0][CNT_W-1:0]  count_q;
    logic [N_CH-1:0][CNT_W-1:0]  count_d;
    logic [N_CH-1:0][CNT_W-1:0]  preset_q;
    logic [N_CH-1:0][1:0]        mode_q;
    logic [N_CH-1:0]             en_q;
    logic [N_CH-1:0]             en_d;
    logic [N_CH-1:0]             im_q;
    logic [N_CH-1:0]             ps_q;
    logic [N_CH-1:0]             pend_q;
    logic [N_CH-1:0]             pend_set;
    logic [N_CH-1:0]             ch_tick;

    assign ch_tick = ~ps_q | {N_CH{psc_tick}};

    // ------------------------------------------------------------------
    // Channel FSMs: next state, next COUNT, hardware EN clear, pending set.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        en_d     = en_q;
        pend_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];

            if (wr_ctrl[i] && !bus.wdata[0]) begin
                // Disable wins over everything else: COUNT freezes and a
                // terminal event on this edge does not set pending.
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        // A CTRL write reaching here carries EN=1.
                        if (wr_ctrl[i]) begin
                            state_d[i] = ST_LOAD;
                        end
                        if (wr_preset[i]) begin
                            count_d[i] = bus.wdata[CNT_W-1:0];
                        end
                    end

                    ST_LOAD: begin
                        count_d[i] = preset_q[i];
                        if (preset_q[i] != '0) begin
                            state_d[i] = ST_RUN;
                        end else begin
                            // Zero period: one-shot fires at once, auto-reload
                            // parks with EN still set and never interrupts.
                            state_d[i] = ST_IDLE;
                            if (mode_q[i] != MODE_AUTO) begin
                                pend_set[i] = 1'b1;
                                en_d[i]     = 1'b0;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (ch_tick[i] && (count_q[i] != '0)) begin
                            count_d[i] = count_q[i] - CNT_W'(1);
                            if (count_q[i] == CNT_W'(1)) begin
                                state_d[i] = ST_DONE;
                            end
                        end
                    end

                    ST_DONE: begin
                        pend_set[i] = 1'b1;
                        if (mode_q[i] == MODE_AUTO) begin
                            // Reload picks up any PRESET written while running.
                            count_d[i] = preset_q[i];
                            state_d[i] = (preset_q[i] != '0) ? ST_RUN : ST_IDLE;
                        end else begin
                            en_d[i]    = 1'b0;
                            state_d[i] = ST_IDLE;
                        end
                    end

                    default: state_d[i] = ST_IDLE;
                endcase
            end

            // A bus write to CTRL always decides the stored EN bit.
            if (wr_ctrl[i]) begin
                en_d[i] = bus.wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the per-channel arrays are a handful of flops, not a RAM,
            // so every element is reset explicitly.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
            end
            count_q  <= '0;
            preset_q <= '0;
            mode_q   <= '0;
            en_q     <= '0;
            im_q     <= '0;
            ps_q     <= '0;
            pend_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                if (wr_ctrl[i]) begin
                    mode_q[i] <= bus.wdata[2:1];
                    im_q[i]   <= bus.wdata[3];
                    ps_q[i]   <= bus.wdata[4];
                end
                if (wr_preset[i]) begin
                    preset_q[i] <= bus.wdata[CNT_W-1:0];
                end
            end
            count_q <= count_d;
            en_q    <= en_d;
            // A hardware set on the same edge as a W1C clear wins.
            pend_q  <= (pend_q & ~status_clr) | pend_set;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupts
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel[i]) begin
                case (word)
                    2'd0:    rdata = 32'({ps_q[i], im_q[i], mode_q[i], en_q[i]});
                    2'd1:    rdata = 32'(preset_q[i]);
                    2'd2:    rdata = 32'(count_q[i]);
                    default: rdata = '0;
                endcase
            end
        end
        if (glb_sel) begin
            case (word)
                2'd0:    rdata = 32'(pend_q);
                2'd1:    rdata = 32'(psc_q);
                default: rdata = '0;
            endcase
        end
    end

    assign bus.rdata = rdata;
    assign irq       = pend_q & im_q;
    assign irq_any   = |irq;

endmodule
